apb_wait_regfile_slave: RTL and testbench
=========================================

Name: apb_wait_regfile_slave

Overview:
- APB responder (completer) for the existing APB master bridge; a drop-in alternative to the zero-wait slaves on either PSEL line.
- Holds a DEPTH x 8 register file and a software-programmable wait-state count that stretches every transfer via PREADY.
- Flags unmapped addresses with PSLVERR.
- Used to exercise the master bridge's wait-state and error paths.

Parameters:
- ADDR_WIDTH, 8, PADDR width (lower address bits as delivered by the top level).
- DATA_WIDTH, 8, PWDATA/PRDATA width.
- DEPTH, 64, number of storage words at addresses 0..DEPTH-1.
- RESET_WAIT, 2, reset value of the wait-state config register (0..15).

Ports:
- PCLK  in  1  clock, rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  transfer address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data; valid only while PREADY=1 on a read.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (PRESET=1, asynchronous):
  - state=IDLE, all storage words=0, wait_cfg=RESET_WAIT, wait counter=0.
  - PREADY=0, PSLVERR=0, PRDATA=0.
- Address map:
  - 0..DEPTH-1: storage.
  - 8'hFF: CFG register. bits[3:0]=wait_cfg, bits[7:4] read 0 and ignore writes.
  - All other addresses: unmapped.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when PSEL=1 and PENABLE=0 (setup phase). On that edge: latch PADDR, PWRITE and PWDATA; load counter with wait_cfg.
  - ACCESS, PSEL=1 and counter!=0: decrement counter; stay in ACCESS.
  - ACCESS, PSEL=1, PENABLE=1 and counter==0: completion cycle. Return to IDLE.
  - ACCESS with PSEL=0 (protocol violation, aborted transfer): go to IDLE. No write, no error, PREADY stays 0.
- Outputs:
  - PREADY = (state==ACCESS) & PSEL & PENABLE & (counter==0). Combinational from registered state.
  - PSLVERR = PREADY & unmapped(latched addr). Reads and writes are treated alike.
  - PRDATA = latched-address read data when PREADY=1 and the latched op is a read; 0 otherwise, including error reads.
- Latency: access phase lasts wait_cfg+1 cycles, so a transfer takes 2+wait_cfg cycles. wait_cfg=0 gives the standard 2-cycle APB transfer.
- Write commit happens on the completion edge only. Storage or CFG updates only when PREADY=1, latched op is a write and the address is mapped.
- Latched values only: PADDR and PWDATA changes during ACCESS are ignored.
- Timing of CFG updates: a CFG write affects the next transfer, not the current one. Readback of CFG returns the new value on the next read.
- Back-to-back transfers: PSEL held high with PENABLE low on the cycle after completion starts a new setup. There are no idle cycles in between.
- Reset mid-transfer: the transfer is abandoned immediately and outputs go to their reset values. The partial write is not committed.
- Address arithmetic: the storage index is the latched address truncated to clog2(DEPTH) bits, used only after the range check passes.

Decomposition:
- Package apb_slave_pkg:
  - state enum {IDLE, ACCESS};
  - CFG_ADDR=8'hFF;
  - WAIT_W=4.
- Sub-module apb_wait_timer: loadable WAIT_W down-counter with zero flag. Inputs: load, load value, decrement enable.
- Storage array and address decode remain in the top module.

Test Plan:
- Reset default, RESET_WAIT=2: write 8'hA5 to addr 8'h10 -> PREADY high on the 3rd access-phase cycle (4-cycle transfer), PSLVERR=0. Read addr 8'h10 -> PRDATA=8'hA5 with PREADY.
- Write 8'h00 to CFG 8'hFF (takes 4 cycles). Next write 8'h3C to addr 8'h3F -> 2-cycle transfer. Read 8'hFF -> PRDATA=8'h00. Then write 8'hF7 to 8'hFF and read 8'hFF -> PRDATA=8'h07, and the subsequent read is a 9-cycle transfer.
- Unmapped access, write 8'h55 to 8'h40 (DEPTH=64) -> PREADY with PSLVERR=1, no storage change. Read 8'h40 -> PSLVERR=1, PRDATA=0.
- Back-to-back, wait_cfg=0: write addr 1, write addr 2, read addr 1 with PSEL continuously high -> each completes in exactly 2 cycles, read returns the first write's data.
- Abort: PSEL drops in cycle 2 of a wait_cfg=3 write to addr 5 -> PREADY never asserted, addr 5 unchanged, next transfer starts normally.
- Reset mid-transfer: assert PRESET during ACCESS of a write to addr 6 -> PREADY/PSLVERR/PRDATA go 0 asynchronously. After release: addr 6 reads 0 and wait_cfg=RESET_WAIT.

Source files
------------

// File: rtl/apb_wait_regfile_slave_pkg.sv
// Purpose: shared types and constants for the wait-state APB register-file responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Address of the wait-state configuration register.
    localparam logic [7:0] CFG_ADDR = 8'hFF;

    // Width of the wait-state count (0..15 extra access cycles).
    localparam int WAIT_W = 4;

endpackage

// File: rtl/apb_wait_regfile_slave_if.sv
// Purpose: APB bus bundle between the master bridge and this responder.
// Latency: n/a (wires only).
// Backpressure: PREADY from the responder stretches the access phase.
interface apb_wait_regfile_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_wait_regfile_slave_timer.sv
// Purpose: loadable wait-state down-counter with a zero flag.
// Latency: load/decrement visible the cycle after the enabling edge; zero flag is combinational from the count.
// Backpressure: none; saturates at zero instead of wrapping.
module apb_wait_timer
    import apb_slave_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              zero_o
);
    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Load has priority over decrement; never count below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WAIT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_wait_regfile_slave.sv
// Purpose: APB responder with a DEPTH x DATA_WIDTH register file, a programmable wait-state CFG register and PSLVERR on unmapped addresses.
// Latency: transfer takes 2 + wait_cfg cycles (setup + wait_cfg+1 access cycles).
// Backpressure: PREADY held low for wait_cfg access cycles; an access phase with PSEL dropped is abandoned with no side effects.
module apb_wait_regfile_slave
    import apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int RESET_WAIT = 2
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    apb_wait_regfile_slave_if.slave  apb
);
    localparam int                    IDX_W        = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_A      = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] CFG_A        = ADDR_WIDTH'(CFG_ADDR);
    localparam logic [WAIT_W-1:0]     RESET_WAIT_V = WAIT_W'(RESET_WAIT);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [WAIT_W-1:0]       wait_cfg_q;
    logic [WAIT_W-1:0]       wait_cfg_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    setup;
    logic                    in_access;
    logic                    cnt_zero;
    logic                    is_store;
    logic                    is_cfg;
    logic                    unmapped;
    logic                    pready;
    logic                    commit;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   rdata;

    // Setup phase is only recognised from IDLE, so a held PSEL after completion restarts cleanly.
    assign setup     = (state_q == IDLE) && apb.PSEL && !apb.PENABLE;
    assign in_access = (state_q == ACCESS);

    // Decode works exclusively on the latched address; live PADDR is ignored after setup.
    assign is_store  = ({1'b0, addr_q} < DEPTH_A);
    assign is_cfg    = (addr_q == CFG_A);
    assign unmapped  = !is_store && !is_cfg;
    assign idx       = addr_q[IDX_W-1:0];

    assign pready    = in_access && apb.PSEL && apb.PENABLE && cnt_zero;
    assign commit    = pready && write_q && !unmapped;

    apb_wait_timer u_timer (
        .clk_i      (PCLK),
        .rst_i      (PRESET),
        .load_i     (setup),
        .load_val_i (wait_cfg_q),
        .dec_i      (in_access && apb.PSEL),
        .zero_o     (cnt_zero)
    );

    // Transfer FSM: latch the request at setup, leave ACCESS on completion or on PSEL abort.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (state_q == IDLE) begin
            if (setup) begin
                state_q <= ACCESS;
                addr_q  <= apb.PADDR;
                write_q <= apb.PWRITE;
                wdata_q <= apb.PWDATA;
            end
        end else if (!apb.PSEL || pready) begin
            state_q <= IDLE;
        end
    end

    // Storage words change only on a committed write to a mapped storage address.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit && is_store) begin
            mem_q[idx] <= wdata_q;
        end
    end

    // CFG next value: only the low nibble is writable; takes effect from the next setup.
    always_comb begin
        wait_cfg_d = wait_cfg_q;
        if (commit && is_cfg) begin
            wait_cfg_d = wdata_q[WAIT_W-1:0];
        end
    end

    // CFG register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cfg_q <= RESET_WAIT_V;
        end else begin
            wait_cfg_q <= wait_cfg_d;
        end
    end

    // Read data is driven only on a successful read completion; zero otherwise.
    always_comb begin
        rdata = '0;
        if (pready && !write_q && !unmapped) begin
            rdata = is_cfg ? DATA_WIDTH'(wait_cfg_q) : mem_q[idx];
        end
    end

    assign apb.PREADY  = pready;
    assign apb.PSLVERR = pready && unmapped;
    assign apb.PRDATA  = rdata;

endmodule

// File: tb/tb_apb_wait_regfile_slave.sv
// Purpose: scoreboard bench for the wait-state APB register-file responder.
// Latency: expectations carry the transfer length in cycles (setup through completion).
// Backpressure: the driver holds the access phase until PREADY, bounded by a cycle budget.
module tb_apb_wait_regfile_slave;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;

    always #5 PCLK = ~PCLK;

    apb_wait_regfile_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    apb_wait_regfile_slave #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .DEPTH      (64),
        .RESET_WAIT (2)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .apb    (bus)
    );

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        logic [7:0] cycles;
    } res_t;

    typedef struct packed {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
    } op_t;

    res_t       sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_mem [64];
    logic [3:0] m_wait;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
        m_wait = 4'd2;
    endtask

    task automatic idle();
        @(posedge PCLK); #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    // Predict the result from the reference model, queue it, then run the transfer.
    // Address/data are scrambled during the access phase; the responder must use its latched copy.
    task automatic xfer(input op_t op, output res_t o);
        res_t e;
        bit   st, cf, done;
        st       = (op.a < 8'd64);
        cf       = (op.a == 8'hFF);
        e.cycles = 8'd2 + {4'h0, m_wait};
        e.err    = !(st || cf);
        e.rdata  = 8'h00;
        if (!op.w && st) e.rdata = m_mem[op.a[5:0]];
        else if (!op.w && cf) e.rdata = {4'h0, m_wait};
        if (op.w && st) m_mem[op.a[5:0]] = op.d;
        if (op.w && cf) m_wait = op.d[3:0];
        sb_q.push_back(e);

        @(posedge PCLK); #1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = op.w;
        bus.PADDR   = op.a;
        bus.PWDATA  = op.d;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        bus.PADDR   = op.a ^ 8'h5A;
        bus.PWDATA  = ~op.d;
        o    = '{rdata: 8'h00, err: 1'b0, cycles: 8'hFF};
        done = 1'b0;
        for (int c = 2; c <= 40; c++) begin
            if (!done) begin
                @(negedge PCLK);
                if (bus.PREADY === 1'b1) begin
                    o.cycles = 8'(c);
                    o.rdata  = bus.PRDATA;
                    o.err    = bus.PSLVERR;
                    done     = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if ({bus.PREADY, bus.PSLVERR, bus.PRDATA} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_in: ready=%b slverr=%b rdata=%h want all 0", bus.PREADY, bus.PSLVERR, bus.PRDATA);
        end
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        n_vec++;
        if ({bus.PREADY, bus.PSLVERR, bus.PRDATA} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_out: ready=%b slverr=%b rdata=%h want all 0", bus.PREADY, bus.PSLVERR, bus.PRDATA);
        end
    endtask

    task automatic test_basic();
        op_t  ops [2];
        res_t o, e;
        ops = '{'{1'b1, 8'h10, 8'hA5}, '{1'b0, 8'h10, 8'h00}};
        foreach (ops[i]) begin
            xfer(ops[i], o);
            idle();
            e = sb_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL basic[%0d]: got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d", i, o.rdata, o.err, o.cycles, e.rdata, e.err, e.cycles);
            end
            n_vec++;
            if (o.cycles !== 8'd4) begin
                n_err++;
                $display("FAIL basic_len[%0d]: got %0d cycles want 4", i, o.cycles);
            end
        end
    endtask

    task automatic test_cfg();
        op_t  ops [6];
        res_t o, e;
        res_t got [6];
        ops = '{'{1'b1, 8'hFF, 8'h00}, '{1'b1, 8'h3F, 8'h3C}, '{1'b0, 8'hFF, 8'h00},
                '{1'b1, 8'hFF, 8'hF7}, '{1'b0, 8'hFF, 8'h00}, '{1'b0, 8'h3F, 8'h00}};
        foreach (ops[i]) begin
            xfer(ops[i], o);
            idle();
            got[i] = o;
            e = sb_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL cfg[%0d]: got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d", i, o.rdata, o.err, o.cycles, e.rdata, e.err, e.cycles);
            end
        end
        n_vec++;
        if (got[0].cycles !== 8'd4 || got[1].cycles !== 8'd2) begin
            n_err++;
            $display("FAIL cfg_len: got %0d,%0d cycles want 4,2", got[0].cycles, got[1].cycles);
        end
        n_vec++;
        if (got[4].rdata !== 8'h07) begin
            n_err++;
            $display("FAIL cfg_readback: got %h want 07", got[4].rdata);
        end
        n_vec++;
        if (got[5].cycles !== 8'd9 || got[5].rdata !== 8'h3C) begin
            n_err++;
            $display("FAIL cfg_wait7: got cyc=%0d rdata=%h want cyc=9 rdata=3c", got[5].cycles, got[5].rdata);
        end
    endtask

    task automatic test_unmapped();
        op_t  ops [6];
        res_t o, e;
        ops = '{'{1'b1, 8'hFF, 8'h01}, '{1'b1, 8'h40, 8'h55}, '{1'b0, 8'h40, 8'h00},
                '{1'b0, 8'h00, 8'h00}, '{1'b1, 8'hFE, 8'h12}, '{1'b0, 8'h80, 8'h00}};
        foreach (ops[i]) begin
            xfer(ops[i], o);
            idle();
            e = sb_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL unmapped[%0d]: got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d", i, o.rdata, o.err, o.cycles, e.rdata, e.err, e.cycles);
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t  ops [4];
        res_t o, e;
        ops = '{'{1'b1, 8'hFF, 8'h00}, '{1'b1, 8'h01, 8'h6B}, '{1'b1, 8'h02, 8'hD2}, '{1'b0, 8'h01, 8'h00}};
        foreach (ops[i]) begin
            xfer(ops[i], o);
            e = sb_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL b2b[%0d]: got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d", i, o.rdata, o.err, o.cycles, e.rdata, e.err, e.cycles);
            end
        end
        idle();
        n_vec++;
        if (o.rdata !== 8'h6B || o.cycles !== 8'd2) begin
            n_err++;
            $display("FAIL b2b_read: got rdata=%h cyc=%0d want rdata=6b cyc=2", o.rdata, o.cycles);
        end
    endtask

    task automatic test_abort();
        op_t  ops [2];
        res_t o, e;
        bit   seen;
        ops = '{'{1'b1, 8'hFF, 8'h03}, '{1'b1, 8'h05, 8'h11}};
        foreach (ops[i]) begin
            xfer(ops[i], o);
            idle();
            e = sb_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL abort_prep[%0d]: got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d", i, o.rdata, o.err, o.cycles, e.rdata, e.err, e.cycles);
            end
        end
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 8'h05; bus.PWDATA = 8'hEE;
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge PCLK);
            if (bus.PREADY !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL abort_ready: PREADY seen high want never");
        end
        xfer('{1'b0, 8'h05, 8'h00}, o);
        idle();
        e = sb_q.pop_front();
        n_vec++;
        if (o !== e || o.rdata !== 8'h11 || o.cycles !== 8'd5) begin
            n_err++;
            $display("FAIL abort_after: got rdata=%h cyc=%0d want rdata=11 cyc=5", o.rdata, o.cycles);
        end
    endtask

    task automatic test_reset_mid();
        res_t o, e;
        xfer('{1'b1, 8'hFF, 8'h00}, o);
        idle();
        e = sb_q.pop_front();
        n_vec++;
        if (o !== e) begin
            n_err++;
            $display("FAIL rstmid_prep: got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d", o.rdata, o.err, o.cycles, e.rdata, e.err, e.cycles);
        end
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 8'h06; bus.PWDATA = 8'h99;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        #2;
        n_vec++;
        if (bus.PREADY !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre: ready=%b want 1", bus.PREADY);
        end
        PRESET = 1'b1;
        #1;
        n_vec++;
        if ({bus.PREADY, bus.PSLVERR, bus.PRDATA} !== 10'b0) begin
            n_err++;
            $display("FAIL rstmid_async: ready=%b slverr=%b rdata=%h want all 0", bus.PREADY, bus.PSLVERR, bus.PRDATA);
        end
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        model_reset();
        xfer('{1'b0, 8'h06, 8'h00}, o);
        idle();
        e = sb_q.pop_front();
        n_vec++;
        if (o !== e || o.rdata !== 8'h00 || o.cycles !== 8'd4) begin
            n_err++;
            $display("FAIL rstmid_addr6: got rdata=%h cyc=%0d want rdata=00 cyc=4", o.rdata, o.cycles);
        end
        xfer('{1'b0, 8'hFF, 8'h00}, o);
        idle();
        e = sb_q.pop_front();
        n_vec++;
        if (o !== e || o.rdata !== 8'h02) begin
            n_err++;
            $display("FAIL rstmid_cfg: got rdata=%h want 02", o.rdata);
        end
    endtask

    task automatic test_random();
        op_t  op;
        res_t o, e;
        int   k;
        for (int i = 0; i < 40; i++) begin
            k    = $urandom_range(0, 9);
            op.w = 1'($urandom_range(0, 1));
            op.d = 8'($urandom_range(0, 255));
            if (k < 6)      op.a = 8'($urandom_range(0, 63));
            else if (k < 8) op.a = 8'hFF;
            else            op.a = 8'($urandom_range(64, 254));
            xfer(op, o);
            if ($urandom_range(0, 1) == 0) idle();
            e = sb_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL random[%0d] w=%b a=%h: got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d", i, op.w, op.a, o.rdata, o.err, o.cycles, e.rdata, e.err, e.cycles);
            end
        end
        idle();
    endtask

    initial begin
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 8'h00;
        bus.PWDATA  = 8'h00;
        model_reset();
        test_reset();
        test_basic();
        test_cfg();
        test_unmapped();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
